slot_display_scan: RTL and testbench

// - Downstream consumer of the four-digit random generator outputs (randNum1..randNum4).
// - Snapshots the four 4-bit digits once per scan frame and time-multiplexes them onto a 4-digit

---
 rtl/slot_display_scan_if.sv | 22 ++
 rtl/slot_display_scan.sv | 147 ++++++++++++++
 tb/tb_slot_display_scan.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/slot_display_scan_if.sv
// rtl/slot_display_scan_if.sv - digit inputs and display outputs of slot_display_scan
interface slot_display_scan_if;
    logic [3:0] randNum1;
    logic [3:0] randNum2;
    logic [3:0] randNum3;
    logic [3:0] randNum4;
    logic [3:0] an;
    logic [6:0] seg;
    logic       match;

    // master drives the four digits and observes the display
    modport master (
        output randNum1, randNum2, randNum3, randNum4,
        input  an, seg, match
    );

    // slave is the scanner: consumes digits, drives the display
    modport slave (
        input  randNum1, randNum2, randNum3, randNum4,
        output an, seg, match
    );
endinterface

// File: rtl/slot_display_scan.sv
// rtl/slot_display_scan.sv - 4-digit 7-segment scanner with match flag, optional blink (BLINK_ON_MATCH_EN)
module slot_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic               clk,
    input  logic               reset,
    slot_display_scan_if.slave disp
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);

    generate
        if (REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_params
            $error("slot_display_scan: REFRESH_DIV must be >= 2 and BLINK_FRAMES >= 1");
        end
    endgenerate

    // active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
    function automatic logic [6:0] hexdec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    didx_q, didx_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          match_q, match_d;
    logic          tick;
    logic          frame_tick;
    logic          blank;
    logic [3:0]    cur_nib;

    // refresh divider, digit index and once-per-frame snapshot of the inputs
    always_comb begin
        tick       = (rcnt_q == RCNT_LAST);
        frame_tick = tick && (didx_q == 2'd3);
        rcnt_d     = tick ? '0 : rcnt_q + RW'(1);
        didx_d     = tick ? didx_q + 2'd1 : didx_q;
        snap_d     = snap_q;
        if (frame_tick) begin
            snap_d = {disp.randNum1, disp.randNum2, disp.randNum3, disp.randNum4};
        end
    end

    // digit select, segment decode and four-of-a-kind compare on the snapshot
    always_comb begin
        case (didx_q)
            2'd0:    cur_nib = snap_q[15:12];
            2'd1:    cur_nib = snap_q[11:8];
            2'd2:    cur_nib = snap_q[7:4];
            default: cur_nib = snap_q[3:0];
        endcase
        an_d    = blank ? 4'b1111 : ~(4'b1000 >> didx_q);
        seg_d   = hexdec(cur_nib);
        match_d = (snap_q[15:12] == snap_q[11:8]) &&
                  (snap_q[11:8]  == snap_q[7:4])  &&
                  (snap_q[7:4]   == snap_q[3:0]);
    end

    // scan state and registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt_q  <= '0;
            didx_q  <= 2'd0;
            snap_q  <= 16'h0000;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            match_q <= 1'b0;
        end else begin
            rcnt_q  <= rcnt_d;
            didx_q  <= didx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            match_q <= match_d;
        end
    end

`ifdef BLINK_ON_MATCH_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    // blank only while the match still holds, so a dropped match unblanks on the very next edge
    assign blank = phase_q && match_q;

    // frame counter toggles the blink phase every BLINK_FRAMES frames while matched
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!match_q) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (frame_tick) begin
            if (bcnt_q == BCNT_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    // blink state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`else
    // without blinking the display is never blanked outside reset
    assign blank = 1'b0;
`endif

    assign disp.an    = an_q;
    assign disp.seg   = seg_q;
    assign disp.match = match_q;

endmodule

// File: tb/tb_slot_display_scan.sv
// tb/tb_slot_display_scan.sv - self-checking bench for slot_display_scan
module tb_slot_display_scan;

    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FR = 4 * RD;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [3:0] SCAN_AN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [6:0] SEG_1234 [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

    typedef struct {
        logic [15:0] digits;
        logic [27:0] segs;
        logic        m;
    } vec_t;

    logic clk;
    logic reset;
    slot_display_scan_if bus();

    slot_display_scan #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors;
    int          checks;
    int          n;
    logic [15:0] snap_m;
    logic        mprev;
    int          bcount;
    logic        phase_m;
    vec_t        tbl [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, n);
        end
    endtask

    function automatic logic all_eq(input logic [15:0] v);
        return (v[15:12] == v[11:8]) && (v[11:8] == v[7:4]) && (v[7:4] == v[3:0]);
    endfunction

    task automatic set_in(input logic [15:0] v);
        bus.randNum1 = v[15:12];
        bus.randNum2 = v[11:8];
        bus.randNum3 = v[7:4];
        bus.randNum4 = v[3:0];
    endtask

    // one clock edge; compare against a model derived from the edge count since reset release
    task automatic step();
        int         d;
        logic [3:0] nib;
        logic [3:0] ea;
        logic       blank;
        @(posedge clk);
        #1;
        n++;
        d     = ((n - 1) / RD) % 4;
        nib   = snap_m[(3 - d) * 4 +: 4];
        blank = 1'b0;
`ifdef BLINK_ON_MATCH_EN
        blank = phase_m && mprev;
`endif
        ea = 4'b1111;
        if (!blank) ea[3 - d] = 1'b0;
        check("an", {28'd0, bus.an}, {28'd0, ea});
        check("seg", {25'd0, bus.seg}, {25'd0, HEX[nib]});
        check("match", {31'd0, bus.match}, {31'd0, all_eq(snap_m)});
        if (!mprev) bcount = 0;
        else if (n % FR == 0) bcount++;
        phase_m = ((bcount / BF) % 2) == 1;
        mprev   = all_eq(snap_m);
        if (n % FR == 0) snap_m = {bus.randNum1, bus.randNum2, bus.randNum3, bus.randNum4};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", {28'd0, bus.an}, 32'hF);
        check("rst_seg", {25'd0, bus.seg}, 32'h7F);
        check("rst_match", {31'd0, bus.match}, 32'd0);
        reset   = 1'b1;
        n       = 0;
        snap_m  = 16'h0000;
        mprev   = 1'b0;
        bcount  = 0;
        phase_m = 1'b0;
    endtask

    // present v so that it is captured by the next frame snapshot
    task automatic to_load(input logic [15:0] v);
        while (n % FR != FR - 1) step();
        set_in(v);
        step();
    endtask

    initial begin
        int k;
        errors = 0;
        checks = 0;
        n      = 0;
        reset  = 1'b0;
        set_in(16'h1234);

        tbl[0] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0};
        tbl[1] = '{16'hAAAA, {7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000}, 1'b1};
        tbl[2] = '{16'h5678, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 1'b0};
        tbl[3] = '{16'h9BCD, {7'b0010000, 7'b0000011, 7'b1000110, 7'b0100001}, 1'b0};
        tbl[4] = '{16'hEF0E, {7'b0000110, 7'b0001110, 7'b1000000, 7'b0000110}, 1'b0};
        tbl[5] = '{16'h7777, {7'b1111000, 7'b1111000, 7'b1111000, 7'b1111000}, 1'b1};

        do_reset();

        // first edge after release shows digit 0 of the zero snapshot
        step();
        check("first_an", {28'd0, bus.an}, 32'h7);
        check("first_seg", {25'd0, bus.seg}, {25'd0, 7'b1000000});
        check("first_match", {31'd0, bus.match}, 32'd1);
        while (n < FR) step();

        // second frame shows the 1,2,3,4 captured at the end of the first
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < RD; j++) begin
                step();
                check("scan_an", {28'd0, bus.an}, {28'd0, SCAN_AN[p]});
                check("scan_seg", {25'd0, bus.seg}, {25'd0, SEG_1234[p]});
                check("scan_match", {31'd0, bus.match}, 32'd0);
            end
        end

        // table of digit sets and their decoded frames
        for (int t = 0; t < 6; t++) begin
            to_load(tbl[t].digits);
            for (int p = 0; p < 4; p++) begin
                step();
                check("tbl_seg", {25'd0, bus.seg}, {25'd0, tbl[t].segs[27 - 7 * p -: 7]});
                check("tbl_match", {31'd0, bus.match}, {31'd0, tbl[t].m});
                repeat (RD - 1) step();
            end
        end

        // mid-frame input change is invisible until the next snapshot
        to_load(16'h1234);
        while (n % FR != 9) step();
        bus.randNum1 = 4'h8;
        while (n % FR != 0) step();
        step();
        check("mid_an", {28'd0, bus.an}, 32'h7);
        check("mid_seg", {25'd0, bus.seg}, {25'd0, 7'b0000000});

        // randomized digits, with some four-of-a-kind sets mixed in
        repeat (600) begin
            step();
            if ($urandom % 6 == 0) begin
                if ($urandom % 3 == 0) begin
                    k = $urandom_range(0, 15);
                    set_in({4'(k), 4'(k), 4'(k), 4'(k)});
                end else begin
                    set_in(16'($urandom));
                end
            end
        end

        // four-of-a-kind hold, then a match drop
        to_load(16'hAAAA);
`ifdef BLINK_ON_MATCH_EN
        k = 0;
        while (bus.an != 4'b1111 && k < 200) begin
            step();
            k++;
        end
        check("blank_seen", {31'd0, (bus.an == 4'b1111)}, 32'd1);
        bus.randNum4 = 4'h3;
        repeat (3 * FR) step();
`else
        repeat (6 * FR) begin
            step();
            check("never_blank", {31'd0, (bus.an != 4'b1111)}, 32'd1);
        end
        bus.randNum4 = 4'h3;
        repeat (2 * FR) step();
`endif

        // asynchronous reset between clock edges
        set_in(16'h4321);
        repeat (5) step();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_an", {28'd0, bus.an}, 32'hF);
        check("async_seg", {25'd0, bus.seg}, 32'h7F);
        check("async_match", {31'd0, bus.match}, 32'd0);
        do_reset();
        repeat (3 * FR) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
